// File: rtl/axi4_lite_master_arbiter.sv
// Two-requester round-robin arbiter that sequences single-beat commands onto one AXI4-Lite
// master port, one transaction outstanding at a time.
module axi4_lite_master_arbiter (
  input  logic        i_aclk,
  input  logic        i_areset,
  // requester side
  input  logic [1:0]  i_req_valid,
  input  logic [1:0]  i_req_write,
  input  logic [63:0] i_req_addr,
  input  logic [5:0]  i_req_prot,
  input  logic [63:0] i_req_wdata,
  input  logic [7:0]  i_req_wstrb,
  output logic [1:0]  o_req_ready,
  output logic [1:0]  o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic [1:0]  o_rsp_resp,
  // AXI4-Lite master
  output logic [31:0] o_awaddr,
  output logic [2:0]  o_awprot,
  output logic        o_awvalid,
  input  logic        i_awready,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic        o_wvalid,
  input  logic        i_wready,
  input  logic [1:0]  i_bresp,
  input  logic        i_bvalid,
  output logic        o_bready,
  output logic [31:0] o_araddr,
  output logic [2:0]  o_arprot,
  output logic        o_arvalid,
  input  logic        i_arready,
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_rresp,
  input  logic        i_rvalid,
  output logic        o_rready
);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StWresp,
    StRead,
    StRdata,
    StDone
  } state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic        r_last;
  logic        r_grant;
  logic [31:0] r_addr;
  logic [2:0]  r_prot;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_awvalid;
  logic        r_wvalid;
  logic [31:0] r_rsp_rdata;
  logic [1:0]  r_rsp_resp;

  logic        w_grant;
  logic        w_take;
  logic        w_write_sel;
  logic        w_aw_done;
  logic        w_w_done;

  // On a tie the requester that was not served last wins.
  assign w_grant     = i_req_valid[1] & (~i_req_valid[0] | ~r_last);
  assign w_take      = (r_state == StIdle) & (|i_req_valid) & ~i_areset;
  assign w_write_sel = w_grant ? i_req_write[1] : i_req_write[0];
  assign w_aw_done   = ~r_awvalid | i_awready;
  assign w_w_done    = ~r_wvalid | i_wready;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_take) w_state_next = w_write_sel ? StWrite : StRead;
      StWrite: if (w_aw_done && w_w_done) w_state_next = StWresp;
      StWresp: if (i_bvalid) w_state_next = StDone;
      StRead:  if (i_arready) w_state_next = StRdata;
      StRdata: if (i_rvalid) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_last      <= 1'b1;
      r_grant     <= 1'b0;
      r_addr      <= '0;
      r_prot      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_take) begin
            r_grant   <= w_grant;
            r_addr    <= w_grant ? i_req_addr[63:32]  : i_req_addr[31:0];
            r_prot    <= w_grant ? i_req_prot[5:3]    : i_req_prot[2:0];
            r_wdata   <= w_grant ? i_req_wdata[63:32] : i_req_wdata[31:0];
            r_wstrb   <= w_grant ? i_req_wstrb[7:4]   : i_req_wstrb[3:0];
            r_awvalid <= w_write_sel;
            r_wvalid  <= w_write_sel;
          end
        end
        StWrite: begin
          if (r_awvalid && i_awready) r_awvalid <= 1'b0;
          if (r_wvalid && i_wready)   r_wvalid  <= 1'b0;
        end
        StWresp: if (i_bvalid) r_rsp_resp <= i_bresp;
        StRdata: begin
          if (i_rvalid) begin
            r_rsp_rdata <= i_rdata;
            r_rsp_resp  <= i_rresp;
          end
        end
        StDone:  r_last <= r_grant;
        default: ;
      endcase
    end
  end

  // Every AXI output comes straight from a register; no AXI input reaches an AXI output.
  assign o_req_ready = w_take ? (w_grant ? 2'b10 : 2'b01) : 2'b00;
  assign o_rsp_valid = (r_state == StDone) ? (r_grant ? 2'b10 : 2'b01) : 2'b00;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_resp  = r_rsp_resp;
  assign o_awaddr    = r_addr;
  assign o_awprot    = r_prot;
  assign o_awvalid   = r_awvalid;
  assign o_wdata     = r_wdata;
  assign o_wstrb     = r_wstrb;
  assign o_wvalid    = r_wvalid;
  assign o_bready    = (r_state == StWresp);
  assign o_araddr    = r_addr;
  assign o_arprot    = r_prot;
  assign o_arvalid   = (r_state == StRead);
  assign o_rready    = (r_state == StRdata);

endmodule
